adc_acq_ctrl: RTL and testbench

Capture sequencer for the 14-bit CMOS ADC path. It runs in the ADC sample clock domain and owns the write port of the 8K x 16 ADC capture RAM. The block arms on a register-interface command, waits for a trigger from `i_sync` (edge-selected) or fires immediately, waits a programmable delay, then writes exactly `len+1` consecutive samples. It reports busy, done and missed-trigger status back to the register block.

---
 rtl/adc_acq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_adc_acq_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_acq_ctrl.sv
// Purpose : ADC capture sequencer; arms on command, waits for an i_sync edge (or
//           fires at once), waits a programmable delay, then writes len+1 samples.
// Latency : first RAM write D+1 cycles after trigger acceptance; all outputs registered.
// Backpressure: none; the RAM write port always accepts, the burst is never stalled.
//
// Ports:
//   i_clk, i_rst_n         ADC sample clock, asynchronous active-low reset
//   i_arm, i_abort         single-cycle commands from the register block (abort wins)
//   i_len, i_delay         capture length minus one, post-trigger delay in cycles
//   i_trig_mode            00 immediate, 01 rising, 10 falling, 11 either edge of i_sync
//   i_sync                 asynchronous trigger, synchronised internally
//   i_adc_data             retimed ADC sample
//   o_ram_we/addr/data     capture RAM port-B write port
//   o_busy, o_done         status: busy in ARMED/DELAY/CAPTURE, sticky done
//   o_missed               saturating count of trigger edges seen while already triggered
//   o_state                state code (IDLE=0, ARMED=1, DELAY=2, CAPTURE=3, DONE=4)

module adc_acq_ctrl #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 14,
    parameter int DLY_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_arm,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_len,
    input  logic [DLY_W-1:0]  i_delay,
    input  logic [1:0]        i_trig_mode,
    input  logic              i_sync,
    input  logic [DATA_W-1:0] i_adc_data,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [15:0]       o_ram_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [7:0]        o_missed,
    output logic [2:0]        o_state
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARMED   = 3'd1;
    localparam logic [2:0] ST_DELAY   = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]        sync_z;
    logic              sync_rise;
    logic              sync_fall;
    logic              trig;
    logic              edge_hit;
    logic              arm_ok;
    logic              in_window;

    logic [2:0]        state;
    logic [ADDR_W-1:0] len_q;
    logic [DLY_W-1:0]  dly_q;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] addr_cnt;
    logic [DLY_W-1:0]  dly_cnt;
    logic              done_q;
    logic [7:0]        missed_q;

    // Two flops for metastability, the third gives the previous level for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_z <= 3'b000;
        end else begin
            sync_z <= {sync_z[1:0], i_sync};
        end
    end

    always_comb begin
        sync_rise = sync_z[1] & ~sync_z[2];
        sync_fall = ~sync_z[1] & sync_z[2];
        trig      = 1'b0;
        edge_hit  = 1'b0;
        // Trigger selection always uses the mode latched at arm time.
        case (mode_q)
            2'b00: begin
                trig     = 1'b1;
                edge_hit = 1'b0;
            end
            2'b01: begin
                trig     = sync_rise;
                edge_hit = sync_rise;
            end
            2'b10: begin
                trig     = sync_fall;
                edge_hit = sync_fall;
            end
            default: begin
                trig     = sync_rise | sync_fall;
                edge_hit = sync_rise | sync_fall;
            end
        endcase
        arm_ok    = i_arm & ~i_abort & ((state == ST_IDLE) | (state == ST_DONE));
        in_window = (state == ST_DELAY) | (state == ST_CAPTURE);
    end

    // Sequencer: the address counter is only meaningful in CAPTURE, the delay
    // counter only in DELAY.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            dly_q    <= '0;
            mode_q   <= 2'b00;
            addr_cnt <= '0;
            dly_cnt  <= '0;
            done_q   <= 1'b0;
        end else if (i_abort) begin
            // Shadow registers and done flag are deliberately left untouched.
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_arm) begin
                        state  <= ST_ARMED;
                        len_q  <= i_len;
                        dly_q  <= i_delay;
                        mode_q <= i_trig_mode;
                        done_q <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (trig) begin
                        if (dly_q != '0) begin
                            state   <= ST_DELAY;
                            dly_cnt <= dly_q - DLY_W'(1);
                        end else begin
                            state    <= ST_CAPTURE;
                            addr_cnt <= '0;
                        end
                    end
                end
                ST_DELAY: begin
                    if (dly_cnt == '0) begin
                        state    <= ST_CAPTURE;
                        addr_cnt <= '0;
                    end else begin
                        dly_cnt <= dly_cnt - DLY_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    // Compare before increment so len = all-ones never wraps.
                    if (addr_cnt == len_q) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end else begin
                        addr_cnt <= addr_cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Missed-trigger counter: edges arriving after the trigger was already taken.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            missed_q <= 8'd0;
        end else if (arm_ok) begin
            missed_q <= 8'd0;
        end else if (in_window && edge_hit && (missed_q != 8'hFF)) begin
            missed_q <= missed_q + 8'd1;
        end
    end

    // Output stage: one register behind the sequencer, except that abort
    // forces the write enable and busy low on the abort edge itself.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ram_we   <= 1'b0;
            o_ram_addr <= '0;
            o_ram_data <= 16'd0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_missed   <= 8'd0;
            o_state    <= ST_IDLE;
        end else begin
            o_ram_we   <= ~i_abort & (state == ST_CAPTURE);
            o_ram_addr <= addr_cnt;
            o_ram_data <= {{(16-DATA_W){1'b0}}, i_adc_data};
            o_busy     <= ~i_abort & ((state == ST_ARMED) | (state == ST_DELAY) |
                                      (state == ST_CAPTURE));
            o_done     <= done_q;
            o_missed   <= missed_q;
            o_state    <= i_abort ? ST_IDLE : state;
        end
    end

endmodule

// File: tb/tb_adc_acq_ctrl.sv
module tb_adc_acq_ctrl;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 14;
    localparam int DLY_W  = 16;
    localparam int BIG    = 1 << 30;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_arm;
    logic              i_abort;
    logic [ADDR_W-1:0] i_len;
    logic [DLY_W-1:0]  i_delay;
    logic [1:0]        i_trig_mode;
    logic              i_sync;
    logic [DATA_W-1:0] i_adc_data;
    logic              o_ram_we;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [15:0]       o_ram_data;
    logic              o_busy;
    logic              o_done;
    logic [7:0]        o_missed;
    logic [2:0]        o_state;

    adc_acq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DLY_W(DLY_W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_arm       (i_arm),
        .i_abort     (i_abort),
        .i_len       (i_len),
        .i_delay     (i_delay),
        .i_trig_mode (i_trig_mode),
        .i_sync      (i_sync),
        .i_adc_data  (i_adc_data),
        .o_ram_we    (o_ram_we),
        .o_ram_addr  (o_ram_addr),
        .o_ram_data  (o_ram_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_missed    (o_missed),
        .o_state     (o_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // cyc == k throughout the interval that follows rising edge k.
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    logic [DATA_W-1:0] adc_prev = '0;
    int ram_cnt [8192];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model: timeline of the current arm ----------------
    // A = arm edge, T = trigger acceptance edge, B = abort edge. Visible outputs:
    // ARMED (A, T], DELAY (T, T+D], CAPTURE (T+D, fin], DONE after fin, fin = T+D+L+1.
    bit m_has;
    int m_A, m_T, m_B, m_D, m_L, m_mode;
    int m_base_state, m_done_base, m_missed_base;
    int m_edges[$];

    function automatic int m_fin();
        return m_T + m_D + m_L + 1;
    endfunction

    function automatic int exp_state(input int c);
        if (c >= m_B) return 0;
        if (!m_has || c <= m_A) return m_base_state;
        if (m_T < 0 || c <= m_T) return 1;
        if (c <= m_T + m_D) return 2;
        if (c <= m_fin()) return 3;
        return 4;
    endfunction

    function automatic int exp_done(input int c);
        if (!m_has || c <= m_A) return m_done_base;
        if (m_T >= 0 && m_fin() < m_B && c > m_fin()) return 1;
        return 0;
    endfunction

    function automatic int exp_missed(input int c);
        int hi;
        int n;
        if (!m_has || c <= m_A) return m_missed_base;
        if (m_T < 0) return 0;
        hi = (m_fin() < m_B) ? m_fin() : m_B;
        n = 0;
        foreach (m_edges[i])
            if (m_edges[i] > m_T && m_edges[i] <= hi && m_edges[i] < c) n++;
        return (n > 255) ? 255 : n;
    endfunction

    task automatic model_reset();
        m_has = 1'b0; m_A = 0; m_T = -1; m_B = BIG; m_D = 0; m_L = 0; m_mode = 0;
        m_base_state = 0; m_done_base = 0; m_missed_base = 0;
        m_edges.delete();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Returns with cyc == A (the edge that sampled the arm).
    task automatic do_arm(input int len, input int dly, input int mode);
        int a;
        int s;
        a = cyc + 1;
        s = exp_state(a);
        i_arm       = 1'b1;
        i_len       = ADDR_W'(len);
        i_delay     = DLY_W'(dly);
        i_trig_mode = 2'(mode);
        if (s == 0 || s == 4) begin
            m_base_state  = s;
            m_done_base   = exp_done(a);
            m_missed_base = exp_missed(a);
            m_has  = 1'b1;
            m_A    = a;
            m_L    = len;
            m_D    = dly;
            m_mode = mode;
            m_B    = BIG;
            m_edges.delete();
            m_T    = (mode == 0) ? a + 1 : -1;
        end
        tick(1);
        i_arm       = 1'b0;
        // Scramble the setup inputs; the capture must use the latched copies.
        i_len       = ADDR_W'(len ^ 5);
        i_delay     = DLY_W'(dly + 7);
        i_trig_mode = 2'(mode ^ 3);
    endtask

    task automatic do_abort(input bit with_arm);
        if (m_B == BIG) m_B = cyc + 1;
        i_abort = 1'b1;
        i_arm   = with_arm;
        tick(1);
        i_abort = 1'b0;
        i_arm   = 1'b0;
    endtask

    // New level is sampled at cyc+1 and becomes a usable edge two edges later.
    task automatic set_sync(input bit lvl);
        int e;
        bit sel;
        e = cyc + 3;
        i_sync = lvl;
        if (m_has) begin
            sel = (m_mode == 3) || (m_mode == 1 && lvl) || (m_mode == 2 && !lvl);
            if (sel) begin
                m_edges.push_back(e);
                if (m_T < 0 && e > m_A && e < m_B) m_T = e;
            end
        end
    endtask

    // ---------------- ADC data source ----------------
    initial begin
        logic [31:0] r;
        i_adc_data = '0;
        forever begin
            @(posedge i_clk);
            adc_prev = i_adc_data;
            #1;
            r = $urandom;
            i_adc_data = r[DATA_W-1:0];
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge i_clk) begin : cmp
        int c;
        int st;
        if (chk_en) begin
            c  = cyc;
            st = exp_state(c);
            check("state",  32'(o_state),  32'(st));
            check("busy",   32'(o_busy),   32'(st >= 1 && st <= 3));
            check("we",     32'(o_ram_we), 32'(st == 3));
            if (st == 3) check("addr", 32'(o_ram_addr), 32'(c - (m_T + m_D + 1)));
            check("done",   32'(o_done),   32'(exp_done(c)));
            check("missed", 32'(o_missed), 32'(exp_missed(c)));
            check("data",   32'(o_ram_data), 32'({2'b00, adc_prev}));
            if (o_ram_we) ram_cnt[o_ram_addr]++;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int bad;
        i_rst_n = 1'b0; i_arm = 1'b0; i_abort = 1'b0; i_len = '0; i_delay = '0;
        i_trig_mode = 2'b00; i_sync = 1'b0;
        model_reset();
        foreach (ram_cnt[i]) ram_cnt[i] = 0;
        tick(2);
        check("rst_we",     32'(o_ram_we),   32'd0);
        check("rst_addr",   32'(o_ram_addr), 32'd0);
        check("rst_data",   32'(o_ram_data), 32'd0);
        check("rst_busy",   32'(o_busy),     32'd0);
        check("rst_done",   32'(o_done),     32'd0);
        check("rst_missed", 32'(o_missed),   32'd0);
        check("rst_state",  32'(o_state),    32'd0);
        i_rst_n = 1'b1;
        tick(1);
        chk_en = 1'b1;

        // Immediate, len 0, delay 0: single write two edges after the arm edge.
        do_arm(0, 0, 0);
        tick(2);
        check("imm_we",   32'(o_ram_we),   32'd1);
        check("imm_addr", 32'(o_ram_addr), 32'd0);
        tick(1);
        check("imm_we_off", 32'(o_ram_we), 32'd0);
        check("imm_done",   32'(o_done),   32'd1);
        check("imm_busy",   32'(o_busy),   32'd0);
        tick(3);

        // Rising, len 99, delay 10: first write 13 edges after the sampling edge.
        do_arm(99, 10, 1);
        tick(3);
        set_sync(1'b1);
        tick(13);
        check("rise_we_early", 32'(o_ram_we), 32'd0);
        tick(1);
        check("rise_we_first", 32'(o_ram_we),   32'd1);
        check("rise_addr0",    32'(o_ram_addr), 32'd0);
        tick(100);
        check("rise_we_end", 32'(o_ram_we), 32'd0);
        check("rise_done",   32'(o_done),   32'd1);
        check("rise_busy",   32'(o_busy),   32'd0);
        set_sync(1'b0);
        tick(5);

        // Falling mode: a rising edge is ignored, the falling edge triggers.
        do_arm(4, 2, 2);
        tick(2);
        set_sync(1'b1);
        tick(10);
        check("fall_still_armed", 32'(o_state), 32'd1);
        check("fall_still_busy",  32'(o_busy),  32'd1);
        set_sync(1'b0);
        tick(12);
        check("fall_done",  32'(o_done),  32'd1);
        check("fall_state", 32'(o_state), 32'd4);

        // Three extra rising edges during a len 999 capture; an arm mid-capture is ignored.
        do_arm(999, 0, 1);
        tick(2);
        set_sync(1'b1);
        tick(10);
        for (int k = 0; k < 3; k++) begin
            set_sync(1'b0);
            tick(20);
            set_sync(1'b1);
            tick(20);
        end
        do_arm(5, 5, 0);
        tick(1000);
        check("missed_three", 32'(o_missed), 32'd3);
        check("missed_done",  32'(o_done),   32'd1);
        do_arm(3, 0, 0);
        tick(1);
        check("rearm_missed", 32'(o_missed), 32'd0);
        check("rearm_done",   32'(o_done),   32'd0);
        tick(8);

        // Abort partway through a len 199 capture, then arm+abort together.
        do_arm(199, 0, 3);
        tick(2);
        set_sync(1'b0);
        tick(53);
        do_abort(1'b0);
        check("abort_we",    32'(o_ram_we), 32'd0);
        check("abort_state", 32'(o_state),  32'd0);
        check("abort_done",  32'(o_done),   32'd0);
        tick(3);
        do_abort(1'b1);
        check("arm_abort_state", 32'(o_state), 32'd0);
        check("arm_abort_busy",  32'(o_busy),  32'd0);
        tick(3);
        check("arm_abort_idle", 32'(o_state), 32'd0);

        // Asynchronous reset mid-capture, then a full-RAM capture.
        do_arm(300, 0, 0);
        tick(20);
        #1;
        chk_en  = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check("arst_we",     32'(o_ram_we),   32'd0);
        check("arst_addr",   32'(o_ram_addr), 32'd0);
        check("arst_data",   32'(o_ram_data), 32'd0);
        check("arst_busy",   32'(o_busy),     32'd0);
        check("arst_done",   32'(o_done),     32'd0);
        check("arst_missed", 32'(o_missed),   32'd0);
        check("arst_state",  32'(o_state),    32'd0);
        tick(2);
        i_rst_n = 1'b1;
        model_reset();
        tick(1);
        foreach (ram_cnt[i]) ram_cnt[i] = 0;
        chk_en = 1'b1;
        do_arm(8191, 0, 0);
        tick(8195);
        bad = 0;
        foreach (ram_cnt[i]) if (ram_cnt[i] != 1) bad++;
        check("full_ram_once", 32'(bad),    32'd0);
        check("full_done",     32'(o_done), 32'd1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
